bit32_div_seq: RTL



---
 rtl/bit32_div_pkg.sv | 26 ++
 rtl/bit32_div_step.sv | 46 ++++
 rtl/bit32_div_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bit32_div_pkg.sv
// Shared types, constants and the 4-bit ripple block for the sequential 32-bit divider.
package bit32_div_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // 4-bit ripple-carry add; returns {carry_out, sum}
  function automatic logic [4:0] rca4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] s;
    logic       c;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return {c, s};
  endfunction

endpackage

// File: rtl/bit32_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor
// through a carry-select chain of 4-bit ripple blocks, keep the difference if it is non-negative.
module bit32_div_step
  import bit32_div_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  localparam int unsigned NBLK = WIDTH / 4;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] divisor_n;
  logic [WIDTH-1:0] diff;
  logic [NBLK:0]    carry;

  assign shifted   = {rem[WIDTH-2:0], in_bit};
  assign divisor_n = ~divisor;
  // Subtraction as shifted + ~divisor + 1
  assign carry[0]  = 1'b1;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    if (i == 0) begin : g_first
      logic [4:0] s;
      assign s           = rca4(shifted[3:0], divisor_n[3:0], 1'b1);
      assign diff[3:0]   = s[3:0];
      assign carry[1]    = s[4];
    end else begin : g_sel
      logic [4:0] s0;
      logic [4:0] s1;
      assign s0              = rca4(shifted[4*i +: 4], divisor_n[4*i +: 4], 1'b0);
      assign s1              = rca4(shifted[4*i +: 4], divisor_n[4*i +: 4], 1'b1);
      assign diff[4*i +: 4]  = carry[i] ? s1[3:0] : s0[3:0];
      assign carry[i+1]      = carry[i] ? s1[4] : s0[4];
    end
  end

  // The bit shifted out of the remainder makes the shifted value 33 bits wide; if it is set the
  // trial always succeeds even though the 32-bit adder reports no carry.
  assign q_bit    = rem[WIDTH-1] | carry[NBLK];
  assign rem_next = q_bit ? diff : shifted;

endmodule

// File: rtl/bit32_div_seq.sv
// Sequential 32-bit restoring divider (DIV/REM unit), one quotient bit per clock.
// Define BIT32_DIV_SIGNED_EN for two's-complement operands (truncating division); otherwise
// operands are unsigned.
module bit32_div_seq
  import bit32_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Magnitude of an operand; identity in the unsigned build
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
`ifdef BIT32_DIV_SIGNED_EN
    return x[WIDTH-1] ? (~x + 1'b1) : x;
`else
    return x;
`endif
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dend_q, dend_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
`ifdef BIT32_DIV_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] quo_final;

  bit32_div_step u_step (
    .rem      (rem_q),
    .in_bit   (quo_q[WIDTH-1]),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .q_bit    (step_qbit)
  );

  assign quo_final = {quo_q[WIDTH-2:0], step_qbit};

  // Next-state, datapath and result capture
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    dend_d      = dend_q;
    div0_d      = div0_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef BIT32_DIV_SIGNED_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dend_d  = dividend;
          dvsr_d  = mag(divisor);
          rem_d   = '0;
          quo_d   = mag(dividend);
          count_d = '0;
          div0_d  = (divisor == '0);
`ifdef BIT32_DIV_SIGNED_EN
          neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d = dividend[WIDTH-1];
`endif
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (div0_q) begin
          // Divide by zero resolves after a single cycle in CALC
          quotient_d  = DIV0_QUOTIENT;
          remainder_d = dend_q;
          dbz_d       = 1'b1;
          state_d     = StDone;
        end else begin
          rem_d   = step_rem;
          quo_d   = quo_final;
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(WIDTH - 1)) begin
`ifdef BIT32_DIV_SIGNED_EN
            quotient_d  = neg_quo_q ? (~quo_final + 1'b1) : quo_final;
            remainder_d = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
`else
            quotient_d  = quo_final;
            remainder_d = step_rem;
`endif
            dbz_d   = 1'b0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      dend_q      <= '0;
      div0_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef BIT32_DIV_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      dend_q      <= dend_d;
      div0_q      <= div0_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef BIT32_DIV_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
